// File: rtl/seq_square_pkg.sv
// seq_square_pkg
//   Shared definitions for the sequential squarer: FSM state encoding width
//   and the state enum used by seq_square.
package seq_square_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/seq_square.sv
// seq_square
//   Sequential shift-add squarer. Accepts a WIDTH-bit operand over a
//   valid/ready handshake, computes its 2*WIDTH-bit square with one partial
//   product per clock (WIDTH clocks), and presents the result over a
//   valid/ready handshake. Trades throughput for area versus a combinational
//   squarer.
//
//   Optional build macro: SEQ_SQUARE_SIGNED_EN
//     defined   - in_data is two's complement; its magnitude is squared.
//     undefined - in_data is unsigned; no negation logic is built.
//
//   Ports
//     clk        rising-edge clock
//     rst        synchronous reset, active-high
//     in_valid   operand present on in_data
//     in_ready   block can accept an operand (IDLE and not in reset)
//     in_data    WIDTH-bit operand
//     out_valid  result valid on out_data (DONE)
//     out_ready  consumer takes the result
//     out_data   2*WIDTH-bit unsigned square, driven from acc at all times
//     busy       high in CALC and DONE
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   IDLE  | waiting for an operand; in_ready high
//   CALC  | one shift-add step per clock, WIDTH steps total
//   DONE  | result held on out_data with out_valid until popped
module seq_square
  import seq_square_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] out_data,
  output logic               busy
);

  localparam int CNT_W = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_t             state_q, state_d;
  logic [2*WIDTH-1:0] acc, mcand;
  logic [WIDTH-1:0]   mult;
  logic [CNT_W-1:0]   cnt;
  logic [WIDTH-1:0]   operand;
  logic               accept;

`ifdef SEQ_SQUARE_SIGNED_EN
  // Magnitude of a two's complement operand. The most negative value wraps
  // to itself in WIDTH bits, which read as unsigned is exactly its magnitude.
  assign operand = in_data[WIDTH-1] ? (~in_data + WIDTH'(1)) : in_data;
`else
  assign operand = in_data;
`endif

  // in_ready is masked by rst so nothing is accepted on a reset edge.
  assign in_ready  = (state_q == IDLE) && !rst;
  assign accept    = in_valid && in_ready;
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign out_data  = acc;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = CALC;
      CALC:    if (cnt == CNT_LAST) state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc   <= '0;
      mcand <= '0;
      mult  <= '0;
      cnt   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            acc   <= '0;
            mcand <= {{WIDTH{1'b0}}, operand};
            mult  <= operand;
            cnt   <= '0;
          end
        end
        CALC: begin
          acc   <= acc + (mult[0] ? mcand : '0);
          mcand <= mcand << 1;
          mult  <= mult >> 1;
          cnt   <= cnt + CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/seq_square.md
# seq_square

Parametrised sequential squarer: accepts an unsigned WIDTH-bit operand over a valid/ready handshake and returns its 2*WIDTH-bit square after an iterative shift-add computation, one partial product per clock. It replaces the fixed 3-bit combinational squarer wherever operands are wider than a few bits and area matters more than throughput. It sits between any valid/ready producer and consumer in the arithmetic projects.

## Interface
- WIDTH, 8, operand width in bits; legal range 2..32.
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous reset, active-high.
- in_valid  input  1  operand present on in_data.
- in_ready  output  1  block can accept an operand.
- in_data  input  WIDTH  operand (unsigned; two's complement when SEQ_SQUARE_SIGNED_EN is defined).
- out_valid  output  1  result valid on out_data.
- out_ready  input  1  consumer takes the result.
- out_data  output  2*WIDTH  square of the accepted operand, always unsigned.
- busy  output  1  high in CALC and DONE.

## Operation
- One clock (clk); reset is synchronous and active-high (rst).
- FSM states: IDLE, CALC, DONE.
- IDLE: in_ready=1. Accept on an edge with in_valid&in_ready: mcand<=operand zero-extended to 2*WIDTH, mult<=operand, acc<=0, cnt<=0, go to CALC.
- CALC: per edge, acc<=acc+(mult[0] ? mcand : 0), mcand<=mcand<<1, mult<=mult>>1, cnt<=cnt+1. On the edge where cnt==WIDTH-1, go to DONE (exactly WIDTH CALC edges).
- DONE: out_valid=1, out_data=acc, held stable until out_valid&out_ready; on that edge go to IDLE.
- in_ready=0 in CALC and DONE; in_valid is ignored there (no queueing).
- out_data is driven from acc in every state; consumers sample it only when out_valid=1.
- Arithmetic: acc and mcand are 2*WIDTH bits; max result (2^WIDTH-1)^2 fits, no overflow, no truncation.
- cnt width is clog2(WIDTH)+1 bits.

## Timing
- Reset values: state=IDLE, acc=0, mcand=0, mult=0, cnt=0, out_valid=0, busy=0, out_data=0. in_ready=0 while rst=1 and in_valid is ignored; in_ready=1 from the first cycle after rst deasserts.
- Latency: out_valid rises exactly WIDTH edges after the accepting edge.
- Throughput: back-to-back operands accepted at most every WIDTH+2 cycles with out_ready tied high (accept, WIDTH calc, pop).
- Pop and accept never share an edge; the next accept is the edge after the pop at the earliest.
- rst asserted in any state, including mid-CALC or DONE with out_ready low: on that edge the result is discarded, all reset values restored, and no out_valid is produced for the aborted operand.
- out_ready high while out_valid is low has no effect.

## Configuration
- SEQ_SQUARE_SIGNED_EN defined: in_data is two's complement; at acceptance the operand is replaced by its magnitude (WIDTH-bit unsigned; -2^(WIDTH-1) maps to 2^(WIDTH-1)), so the square is exact and out_data stays unsigned. Timing is identical.
- Not defined: in_data is unsigned; the negation logic is absent.

## Structure
- Package seq_square_pkg: state enum type (IDLE, CALC, DONE) and the state encoding width constant.
- Single module; no sub-module. The shift-add step is too small to justify one.

## Test plan
- WIDTH=8, in_data=0, out_ready=1 -> out_valid exactly 8 edges after accept, out_data=0, back in IDLE the next cycle.
- WIDTH=8, in_data=255 -> out_data=65025 (0xFE01); busy=1 from accept through pop.
- WIDTH=8, in_data=13, out_ready held low 5 cycles after out_valid -> out_data=169 stable and out_valid high throughout, pop on the first edge with out_ready=1.
- WIDTH=8, in_data=7 accepted, then in_valid=1 with in_data=9 during CALC -> ignored, in_ready=0, result 49; 9 accepted only after the pop, giving 81.
- rst pulsed on the 4th CALC edge of operand 200 -> all outputs at reset values, no out_valid for 200; next operand 3 -> 9.
- SEQ_SQUARE_SIGNED_EN, WIDTH=8: in_data=-128 -> 16384; -3 -> 9; 127 -> 16129.
